alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_seq_shifter.sv | 32 +++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and small helpers for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ROL   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_ROR   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_BREV  = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;
    localparam logic [3:0] OP_MULLO = 4'b1010;
    localparam logic [3:0] OP_MULHI = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Low two opcode bits select the shifter function.
    typedef enum logic [1:0] {
        SH_ROL = 2'b00,
        SH_SLL = 2'b01,
        SH_ROR = 2'b10,
        SH_SRL = 2'b11
    } shift_op_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULLO) || (op == OP_MULHI);
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Combinational rotate/shift unit shared by ROL, SLL, ROR and SRL.
module shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_amt,
    input  shift_op_t                i_op,
    output logic [WIDTH-1:0]         o_data
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [DW-1:0] w_dbl;
    logic [DW-1:0] w_left;
    logic [DW-1:0] w_right;

    // Rotates come from shifting a doubled copy of the operand.
    always_comb begin
        w_dbl   = {i_data, i_data};
        w_left  = w_dbl << i_amt;
        w_right = w_dbl >> i_amt;
        case (i_op)
            SH_ROL:  o_data = w_left[DW-1:WIDTH];
            SH_SLL:  o_data = i_data << i_amt;
            SH_ROR:  o_data = w_right[WIDTH-1:0];
            default: o_data = i_data >> i_amt;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/shift/add ops plus a WIDTH-cycle shift-add multiplier,
// with a valid/ready handshake on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic             Cin,
    input  logic [3:0]       Oper,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             CF,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned SW  = WIDTH + 1;
    localparam int unsigned PW  = 2 * WIDTH;

    state_t           r_state;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_msign;
    logic             r_hi;

    logic [WIDTH-1:0] w_act_a;
    logic [WIDTH-1:0] w_act_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_shift;
    logic [SW-1:0]    w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_of;
    logic             w_cf;
    logic             w_is_mul;
    logic             w_accept;
    logic [SW-1:0]    w_step;
    logic [PW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_mul_res;
    logic             w_mul_of;

    assign in_ready = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    shifter #(.WIDTH(WIDTH)) u_shifter (
        .i_data (w_act_a),
        .i_amt  (w_act_b[SHW-1:0]),
        .i_op   (shift_op_t'(Oper[1:0])),
        .o_data (w_shift)
    );

    // Single-cycle result and flags straight from the request inputs.
    always_comb begin
        w_act_a  = invA ? ~InA : InA;
        w_act_b  = invB ? ~InB : InB;
        w_mag_a  = (sign && w_act_a[WIDTH-1]) ? (~w_act_a + WIDTH'(1)) : w_act_a;
        w_mag_b  = (sign && w_act_b[WIDTH-1]) ? (~w_act_b + WIDTH'(1)) : w_act_b;
        w_sum    = {1'b0, w_act_a} + {1'b0, w_act_b} + SW'(Cin);
        w_is_mul = MUL_EN && is_mul_op(Oper);
        w_res    = '0;
        w_of     = 1'b0;
        w_cf     = 1'b0;
        case (Oper)
            OP_ROL, OP_SLL, OP_ROR, OP_SRL: w_res = w_shift;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = sign ? ((w_act_a[WIDTH-1] == w_act_b[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != w_act_a[WIDTH-1]))
                             : w_sum[WIDTH];
            end
            OP_AND:   w_res = w_act_a & w_act_b;
            OP_OR:    w_res = w_act_a | w_act_b;
            OP_XOR:   w_res = w_act_a ^ w_act_b;
            OP_BREV: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    w_res[i] = w_act_a[WIDTH-1-i];
                end
            end
            OP_PASSB: w_res = w_act_b;
            default:  w_res = '0;
        endcase
    end

    // One shift-add step on {high accumulator, remaining multiplier bits}, plus final sign fix-up.
    always_comb begin
        w_step    = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : SW'(0));
        w_acc_nxt = {w_step, r_acc[WIDTH-1:1]};
        w_prod    = r_neg ? (~w_acc_nxt + PW'(1)) : w_acc_nxt;
        w_mul_res = r_hi ? w_prod[PW-1:WIDTH] : w_prod[WIDTH-1:0];
        w_mul_of  = r_msign ? !((&w_prod[PW-1:WIDTH-1]) || (~|w_prod[PW-1:WIDTH-1]))
                            : (|w_prod[PW-1:WIDTH]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_msign   <= 1'b0;
            r_hi      <= 1'b0;
            Out       <= '0;
            ZF        <= 1'b0;
            SF        <= 1'b0;
            OF        <= 1'b0;
            CF        <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept && w_is_mul) begin
                        r_state   <= ST_MUL;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                        r_acc     <= {WIDTH'(0), w_mag_b};
                        r_mcand   <= w_mag_a;
                        r_cnt     <= '0;
                        r_neg     <= sign && (w_act_a[WIDTH-1] ^ w_act_b[WIDTH-1]);
                        r_msign   <= sign;
                        r_hi      <= (Oper == OP_MULHI);
                    end else if (w_accept) begin
                        r_state   <= ST_DONE;
                        out_valid <= 1'b1;
                        Out       <= w_res;
                        ZF        <= (w_res == '0);
                        SF        <= w_res[WIDTH-1];
                        OF        <= w_of;
                        CF        <= w_cf;
                    end else if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state   <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        Out       <= w_mul_res;
                        ZF        <= (w_mul_res == '0);
                        SF        <= w_mul_res[WIDTH-1];
                        OF        <= w_mul_of;
                        CF        <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: a cycle-timeline reference model checked every cycle,
// plus directed cases with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 16;
    localparam longint MASK = (longint'(1) << W) - 1;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    typedef struct packed {
        logic [W-1:0] out;
        logic         zf;
        logic         sf;
        logic         of;
        logic         cf;
        logic         mul;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] InA;
    logic [W-1:0] InB;
    logic         Cin;
    logic [3:0]   Oper;
    logic         invA;
    logic         invB;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Out;
    logic         ZF;
    logic         SF;
    logic         OF;
    logic         CF;
    logic         busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_cnt = 0;
    bit   m_valid = 1'b0;
    bit   m_rst_chk = 1'b0;
    bit   chk_en = 1'b0;
    res_t m_res;
    res_t m_pend;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .InA       (InA),
        .InB       (InB),
        .Cin       (Cin),
        .Oper      (Oper),
        .invA      (invA),
        .invB      (invB),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .ZF        (ZF),
        .SF        (SF),
        .OF        (OF),
        .CF        (CF),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics computed with plain integer arithmetic.
    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic ia, input logic ib, input logic sg);
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        longint ua, ub, sa, sb, p, r;
        int amt;
        res_t x;
        aa  = ia ? ~a : a;
        bb  = ib ? ~b : b;
        ua  = longint'(aa);
        ub  = longint'(bb);
        sa  = (sg && aa[W-1]) ? ua - (longint'(1) << W) : ua;
        sb  = (sg && bb[W-1]) ? ub - (longint'(1) << W) : ub;
        amt = int'(ub % W);
        x   = '0;
        r   = 0;
        case (op)
            4'd0: r = ((ua << amt) | (ua >> (W - amt))) & MASK;
            4'd1: r = (ua << amt) & MASK;
            4'd2: r = ((ua >> amt) | (ua << (W - amt))) & MASK;
            4'd3: r = ua >> amt;
            4'd4: begin
                p    = ua + ub + longint'(cin);
                r    = p & MASK;
                x.cf = ((p >> W) & 1) != 0;
                if (sg) begin
                    p    = sa + sb + longint'(cin);
                    x.of = (p > MAXS) || (p < MINS);
                end else begin
                    x.of = x.cf;
                end
            end
            4'd5: r = ua & ub;
            4'd6: r = ua | ub;
            4'd7: r = ua ^ ub;
            4'd8: for (int i = 0; i < W; i++) if (aa[i]) r = r | (longint'(1) << (W - 1 - i));
            4'd9: r = ub;
            4'd10, 4'd11: begin
                p     = sa * sb;
                r     = (op == 4'd10) ? (p & MASK) : ((p >>> W) & MASK);
                x.of  = sg ? ((p > MAXS) || (p < MINS)) : (p > MASK);
                x.mul = 1'b1;
            end
            default: r = 0;
        endcase
        x.out = W'(r);
        x.zf  = (x.out == '0);
        x.sf  = x.out[W-1];
        return x;
    endfunction

    // Timeline model: advances on every rising edge from the applied inputs only.
    always @(posedge clk) begin
        res_t t;
        bit   acc;
        if (rst) begin
            m_cnt     = 0;
            m_valid   = 1'b0;
            m_rst_chk = 1'b1;
            chk_en    = 1'b1;
        end else begin
            acc       = in_valid && (m_cnt == 0) && (!m_valid || out_ready);
            m_rst_chk = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_pend;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (acc) begin
                    t = model(Oper, InA, InB, Cin, invA, invB, sign);
                    if (t.mul) begin
                        m_cnt  = W;
                        m_pend = t;
                    end else begin
                        m_valid = 1'b1;
                        m_res   = t;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_rdy;
        #2;
        if (chk_en) begin
            exp_rdy = !rst && (m_cnt == 0) && (!m_valid || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_cnt > 0));
            if (m_valid)
                chk("result", 64'({Out, ZF, SF, OF, CF}),
                    64'({m_res.out, m_res.zf, m_res.sf, m_res.of, m_res.cf}));
            else if (m_rst_chk)
                chk("reset_out", 64'({Out, ZF, SF, OF, CF}), 64'(0));
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(16'h8000);
            3:       return W'(16'h7FFF);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic scramble();
        InA  = W'($urandom);
        InB  = W'($urandom);
        Oper = 4'($urandom);
        Cin  = 1'($urandom);
        invA = 1'($urandom);
        invB = 1'($urandom);
        sign = 1'($urandom);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic ia, input logic ib, input logic sg,
                          input logic [W-1:0] e_out, input logic [3:0] e_fl,
                          input int e_lat, input int e_busy);
        int lat;
        int bsy;
        drain();
        Oper = op; InA = a; InB = b; Cin = c; invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        #1 chk("dir_accept", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        lat = 1;
        bsy = 0;
        #1;
        while (!out_valid && lat < 200) begin
            if (busy) bsy++;
            @(negedge clk);
            #1 lat++;
        end
        chk("dir_latency", 64'(lat), 64'(e_lat));
        chk("dir_busy_cycles", 64'(bsy), 64'(e_busy));
        chk("dir_result", 64'({Out, ZF, SF, OF, CF}), 64'({e_out, e_fl}));
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        InA = '0; InB = '0; Cin = 1'b0; Oper = '0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_outputs", 64'({Out, ZF, SF, OF, CF, out_valid, busy}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // op, A, B, Cin, invA, invB, sign, expected Out, {ZF,SF,OF,CF}, latency, busy cycles
        run_op(4'h4, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 4'b0110, 1, 0);
        run_op(4'h4, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 4'b1011, 1, 0);
        run_op(4'h4, 16'h8000, 16'hFFFF, 0, 0, 0, 1, 16'h7FFF, 4'b0011, 1, 0);
        run_op(4'hA, 16'h0100, 16'h0100, 0, 0, 0, 0, 16'h0000, 4'b1010, 17, 16);
        run_op(4'hB, 16'h0100, 16'h0100, 0, 0, 0, 0, 16'h0001, 4'b0010, 17, 16);
        run_op(4'hA, 16'hFFFD, 16'h0005, 0, 0, 0, 1, 16'hFFF1, 4'b0100, 17, 16);
        run_op(4'hB, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 16'h0000, 4'b1000, 17, 16);
        run_op(4'h0, 16'h8001, 16'h0001, 0, 0, 0, 0, 16'h0003, 4'b0000, 1, 0);
        run_op(4'h1, 16'h00FF, 16'h0014, 0, 0, 0, 0, 16'h0FF0, 4'b0000, 1, 0);
        run_op(4'h2, 16'h0001, 16'h0004, 0, 0, 0, 0, 16'h1000, 4'b0000, 1, 0);
        run_op(4'h3, 16'h8000, 16'h000F, 0, 0, 0, 0, 16'h0001, 4'b0000, 1, 0);
        run_op(4'h5, 16'h00FF, 16'h0F0F, 0, 1, 0, 0, 16'h0F00, 4'b0000, 1, 0);
        run_op(4'h8, 16'h0001, 16'h1234, 0, 0, 0, 0, 16'h8000, 4'b0100, 1, 0);
        run_op(4'h9, 16'h1234, 16'h0000, 0, 0, 1, 0, 16'hFFFF, 4'b0100, 1, 0);
        run_op(4'hC, 16'h0001, 16'h0001, 1, 0, 0, 1, 16'h0000, 4'b1000, 1, 0);

        // Backpressure on an XOR result, then a same-cycle ADD handoff.
        drain();
        Oper = 4'h7; InA = 16'hF0F0; InB = 16'h0FF0; Cin = 0; invA = 0; invB = 0; sign = 0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scramble();
            #1 chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_hold", 64'({out_valid, Out, ZF, SF, OF, CF}), 64'({1'b1, 16'hFF00, 4'b0100}));
            @(negedge clk);
        end
        Oper = 4'h4; InA = 16'h1234; InB = 16'h1111; Cin = 1; invA = 0; invB = 0; sign = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("bp_handoff_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 chk("bp_no_bubble", 64'({out_valid, Out, ZF, SF, OF, CF}), 64'({1'b1, 16'h2346, 4'b0000}));

        // Reset in the middle of a multiply.
        drain();
        Oper = 4'hA; InA = 16'h1234; InB = 16'h0003; Cin = 0; invA = 0; invB = 0; sign = 0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1 chk("mid_mul_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1 chk("abort_rst_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_outputs", 64'({Out, ZF, SF, OF, CF, out_valid, busy}), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            #1 if (out_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'(0));

        // Random traffic with random backpressure, input churn and occasional resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            InA       = pick();
            InB       = pick();
            Oper      = 4'($urandom_range(0, 15));
            Cin       = 1'($urandom);
            invA      = ($urandom_range(0, 3) == 0);
            invB      = ($urandom_range(0, 3) == 0);
            sign      = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 4) @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
